// File: rtl/ha_serial_add_arb.sv
// ha_serial_add_arb
// Round-robin scheduler in front of one bit-serial full-adder cell (two half
// adders plus an OR). A granted requester's operands are latched, added
// LSB-first one bit per clock, and the result is presented with a one-cycle
// done pulse.
//
// Handshake: req is a level request. A requester is granted on the edge where
// the block is IDLE and its req bit is sampled high. Its operands are sampled
// only on that grant edge. It must drop req on the edge after it sees
// done=1 with its own done_id. A req still held then is taken as a new request.
module ha_serial_add_arb #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic [1:0]       gnt,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             done,
  output logic             done_id
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_IDX = 5'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             last_id;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic             carry;
  logic [4:0]       idx;

  logic             grant;
  logic             grant_id;
  logic             last_bit;

  // Bit-serial full adder: two half adders chained, carries ORed.
  logic ha1_s, ha1_c, ha2_s, ha2_c, s_bit, c_next;
  assign ha1_s  = a_sr[0] ^ b_sr[0];
  assign ha1_c  = a_sr[0] & b_sr[0];
  assign ha2_s  = ha1_s ^ carry;
  assign ha2_c  = ha1_s & carry;
  assign s_bit  = ha2_s;
  assign c_next = ha1_c | ha2_c;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next state and round-robin winner selection.
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    grant_id   = 1'b0;
    last_bit   = (idx == LAST_IDX);
    unique case (req)
      2'b01:   grant_id = 1'b0;
      2'b10:   grant_id = 1'b1;
      2'b11:   grant_id = ~last_id;
      default: grant_id = 1'b0;
    endcase
    unique case (state)
      S_IDLE: begin
        if (req != 2'b00) begin
          grant      = 1'b1;
          state_next = S_ADD;
        end
      end
      S_ADD: begin
        if (last_bit) state_next = S_DONE;
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand latch, serial shift/accumulate and grant bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_id <= 1'b1;
      a_sr    <= '0;
      b_sr    <= '0;
      carry   <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      cout    <= 1'b0;
      gnt     <= 2'b00;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (grant) begin
            a_sr    <= grant_id ? a1 : a0;
            b_sr    <= grant_id ? b1 : b0;
            carry   <= 1'b0;
            sum     <= '0;
            idx     <= '0;
            gnt     <= grant_id ? 2'b10 : 2'b01;
            last_id <= grant_id;
          end
        end
        S_ADD: begin
          // The new sum bit enters at the MSB so after WIDTH shifts bit 0 of
          // the operands lands in sum[0].
          sum   <= (sum >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));
          a_sr  <= a_sr >> 1;
          b_sr  <= b_sr >> 1;
          carry <= c_next;
          idx   <= idx + 5'd1;
          if (last_bit) cout <= c_next;
        end
        S_DONE: begin
          gnt <= 2'b00;
        end
        default: gnt <= 2'b00;
      endcase
    end
  end

  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign done_id = done & last_id;

endmodule

// File: tb/tb_ha_serial_add_arb.sv
// Directed testbench for ha_serial_add_arb with a result scoreboard.
module tb_ha_serial_add_arb;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic [1:0]   req;
  logic [W-1:0] a0, b0, a1, b1;
  logic [1:0]   gnt;
  logic         busy;
  logic [W-1:0] sum;
  logic         cout;
  logic         done;
  logic         done_id;

  int n_cmp;
  int n_err;
  int cyc;
  int prev_gnt_cyc;

  // Expected results: {requester id, cout, sum}.
  logic [W+1:0] exp_q[$];

  ha_serial_add_arb #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt(gnt), .busy(busy), .sum(sum), .cout(cout),
    .done(done), .done_id(done_id)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W:0] full;
    full = {1'b0, a} + {1'b0, b};
    exp_q.push_back({id, full});
  endtask

  // Drive req and check the grant that follows the next edge.
  task automatic issue(input logic [1:0] rq, input logic [1:0] exp_gnt, input bit check_gap);
    req = rq;
    tick();
    chk("grant", gnt, exp_gnt);
    chk("busy_at_grant", busy, 1);
    chk("done_at_grant", done, 0);
    if (check_gap) chk("grant_spacing", cyc - prev_gnt_cyc, W + 2);
    prev_gnt_cyc = cyc;
  endtask

  // Wait for done, score it, drop the finished requester's req bit.
  task automatic wait_done(input bit scramble);
    int           lat;
    logic [W+1:0] e;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      if (scramble) begin
        a0 = W'($urandom_range(0, (1 << W) - 1));
        b0 = W'($urandom_range(0, (1 << W) - 1));
      end
      tick();
      chk("gnt_onehot", $onehot(gnt), 1);
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) begin
      chk("done_timeout", 0, 1);
    end else if (exp_q.size() == 0) begin
      chk("unexpected_done", 0, 1);
    end else begin
      e = exp_q.pop_front();
      chk("done_latency", lat, W);
      chk("sum", sum, e[W-1:0]);
      chk("cout", cout, e[W]);
      chk("done_id", done_id, e[W+1]);
      chk("gnt_in_done", gnt, e[W+1] ? 2'b10 : 2'b01);
      req[e[W+1]] = 1'b0;
      tick();
      chk("done_pulse_len", done, 0);
      chk("busy_after_done", busy, 0);
      chk("gnt_after_done", gnt, 0);
      chk("sum_held", sum, e[W-1:0]);
      chk("cout_held", cout, e[W]);
    end
  endtask

  // Directed sequence.
  initial begin
    n_cmp = 0; n_err = 0; cyc = 0; prev_gnt_cyc = 0;
    rst = 1'b1; req = 2'b00;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    tick(); tick();
    rst = 1'b0;

    // Reset state, then idle.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_gnt", gnt, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
      chk("idle_sum", sum, 0);
      chk("idle_cout", cout, 0);
      chk("idle_done_id", done_id, 0);
    end

    // Requester 0: 6 + 7.
    a0 = 4'h6; b0 = 4'h7;
    push_exp(1'b0, a0, b0);
    issue(2'b01, 2'b01, 1'b0);
    wait_done(1'b0);

    // Requester 1: all-ones + 1, then 9 + 9.
    a1 = 4'hF; b1 = 4'h1;
    push_exp(1'b1, a1, b1);
    issue(2'b10, 2'b10, 1'b0);
    wait_done(1'b0);
    a1 = 4'h9; b1 = 4'h9;
    push_exp(1'b1, a1, b1);
    issue(2'b10, 2'b10, 1'b0);
    wait_done(1'b0);

    // Contention twice: order 0 then 1 each time.
    for (int r = 0; r < 2; r++) begin
      a0 = W'($urandom_range(0, 15)); b0 = W'($urandom_range(0, 15));
      a1 = W'($urandom_range(0, 15)); b1 = W'($urandom_range(0, 15));
      push_exp(1'b0, a0, b0);
      push_exp(1'b1, a1, b1);
      issue(2'b11, 2'b01, 1'b0);
      wait_done(1'b0);
      issue(req, 2'b10, 1'b1);
      wait_done(1'b0);
    end

    // Operands scrambled after the grant edge must not matter.
    a0 = 4'hB; b0 = 4'h8;
    push_exp(1'b0, a0, b0);
    issue(2'b01, 2'b01, 1'b0);
    wait_done(1'b1);

    // Reset at bit index 2; rst held while req=11 to show it dominates.
    a0 = 4'h5; b0 = 4'h3;
    issue(2'b01, 2'b01, 1'b0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("rst_busy", busy, 0);
    chk("rst_gnt", gnt, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_done", done, 0);
    req = 2'b11;
    tick();
    chk("rst_dominates_gnt", gnt, 0);
    chk("rst_dominates_done", done, 0);
    rst = 1'b0;
    a0 = 4'h2; b0 = 4'hE; a1 = 4'h7; b1 = 4'h4;
    push_exp(1'b0, a0, b0);
    push_exp(1'b1, a1, b1);
    issue(2'b11, 2'b01, 1'b0);
    wait_done(1'b0);
    issue(req, 2'b10, 1'b1);
    wait_done(1'b0);

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
